dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-ported 64-bit data memory between NUM_REQ requesters: CPU load/store port, NIC
//  receive DMA and NIC transmit DMA.
//  Arbitration is round-robin, with an optional bounded lock for atomic read-modify-write sequences.
//  Each read is routed back to its owner as a tagged return one cycle after the grant.
//  Sits between the four-stage core's memEn/memWrEn/addr_out/d_out port and the data memory.
// PARAMETERS
//  NUM_REQ   3   number of requesters; index 0 = CPU
//  ADDR_W    32  memory address width
//  DATA_W    64  data width
//  MAX_LOCK  4   maximum consecutive granted accesses under lock before ownership is forcibly released
// PORTS
//  clk        in   1                 clock
//  reset      in   1                 synchronous, active-low reset
//  req        in   NUM_REQ           access request per requester; held until gnt
//  we         in   NUM_REQ           1 = write, 0 = read; valid with req
//  lock       in   NUM_REQ           requester wants to keep the port after this access
//  addr       in   NUM_REQ*ADDR_W    flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
//  wdata      in   NUM_REQ*DATA_W    flattened write data
//  gnt        out  NUM_REQ           one-hot grant, combinational in the request cycle
//  rvalid     out  NUM_REQ           one-hot read-data-valid, registered
//  rdata      out  DATA_W            read data, shared by all requesters; qualified by rvalid
//  mem_en     out  1                 memory enable
//  mem_wr_en  out  1                 memory write enable
//  mem_addr   out  ADDR_W            memory address
//  mem_wdata  out  DATA_W            memory write data
//  mem_rdata  in   DATA_W            memory read data, valid the cycle after mem_en & !mem_wr_en
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - ptr=0, owner=none, lock_cnt=0, rd_tag=0.
//    - gnt, rvalid, mem_en, mem_wr_en = 0; mem_addr, mem_wdata = 0.
//    - gnt and mem_* are forced to 0 during every reset cycle.
//  - Arbitration, cycle T:
//    - If an owner exists and req[owner]=1, gnt=owner.
//    - If an owner exists and req[owner]=0, ownership is released and normal arbitration runs in the same cycle.
//    - Otherwise grant goes to the first requester with req=1, scanning ptr, ptr+1, ... mod NUM_REQ.
//    - At most one gnt bit is high.
//  - Memory drive, cycle T: mem_en=|gnt; mem_wr_en=we[w]; mem_addr=addr[w]; mem_wdata=wdata[w].
//    With no grant, mem_* = 0.
//  - Pointer: at posedge after a grant to w, ptr <= (w+1) mod NUM_REQ. No grant -> ptr unchanged.
//  - Lock / ownership:
//    - Granted with lock[w]=1 and lock_cnt<MAX_LOCK-1: owner<=w, lock_cnt++.
//    - Granted with lock[w]=0, or lock_cnt reaches MAX_LOCK-1: owner<=none, lock_cnt<=0.
//    - A forced release leaves ptr past w, so other requesters win next.
//  - Read return:
//    - A granted read in T sets rd_tag<=gnt at the posedge.
//    - In T+1, rvalid=rd_tag and rdata=mem_rdata (combinational passthrough).
//    - Writes produce no rvalid.
//    - Read latency: gnt to rvalid = 1 cycle.
//    - Back-to-back reads from different requesters return in grant order, one per cycle.
//  - A requester dropping req without a grant is legal; it does not consume a turn.
//  - Reset mid-operation: an outstanding rd_tag is cleared, so that read's rvalid is never issued.
//    Lock state is cleared.
//  - Simultaneous request from the current owner and others: owner wins until its lock ends or MAX_LOCK expires.
//  - Write then read to the same address in consecutive cycles: the read returns new data
//    (memory write-first; the arbiter adds no reordering).
// STRUCTURE
//  - Package dmem_arb_pkg: ADDR_W/DATA_W defaults; requester index constants REQ_CPU=0, REQ_NIC_RX=1, REQ_NIC_TX=2.
//  - Sub-module rr_pick (combinational): inputs req vector and ptr; output one-hot winner via rotate / priority / rotate-back.
//  - Top level holds ptr, owner, lock_cnt, rd_tag and the mem mux.
// TESTING
//  1. Reset held 2 cycles with req=3'b111: gnt=0, mem_en=0, rvalid=0. First cycle after release: gnt=3'b001.
//  2. req=3'b111 held with no lock for 6 cycles: gnt sequence 001,010,100,001,010,100.
//  3. Read from req1, addr=0x10, mem holding 0xDEAD_BEEF: gnt[1] in T, mem_addr=0x10, mem_wr_en=0;
//     rvalid=3'b010 and rdata=0xDEADBEEF in T+1.
//  4. req0 with lock=1 continuously, req1 also requesting, MAX_LOCK=4: gnt=001 for 4 cycles, then 010.
//  5. Read granted to req2, reset asserted in the next cycle: rvalid stays 0 and ptr returns to 0.
//  6. Write by req0 (addr 0x8, wdata 0x5) then read by req1 (addr 0x8) in consecutive cycles:
//     mem_wr_en=1 then 0; rvalid=010 with rdata=0x5.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Default widths, requester count, lock bound and requester indices.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W   = 32;
  localparam int DMEM_DATA_W   = 64;
  localparam int DMEM_NUM_REQ  = 3;
  localparam int DMEM_MAX_LOCK = 4;

  typedef enum logic [1:0] {
    REQ_CPU    = 2'd0,
    REQ_NIC_RX = 2'd1,
    REQ_NIC_TX = 2'd2
  } req_id_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Round-robin winner pick: rotate by ptr, lowest-set priority, rotate back.
// Ports: req (request vector), ptr (first index to consider), gnt (one-hot winner or 0).
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rq;
  logic [N-1:0] pri;

  // rq[i] is the request of requester (ptr+i) mod N
  always_comb begin
    rq = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = i + int'(ptr);
      if (k >= N) k = k - N;
      rq[i] = req[k];
    end
  end

  assign pri = rq & (~rq + N'(1));

  always_comb begin
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      int k;
      k = j - int'(ptr);
      if (k < 0) k = k + N;
      gnt[j] = pri[k];
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin data-memory port arbiter with bounded lock and tagged read return.
// Ports: req/we/lock/addr/wdata per requester in; gnt/rvalid/rdata out; mem_* to memory.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ  = DMEM_NUM_REQ,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic               owner_v;
  logic [LW-1:0]      lock_cnt;
  logic [NUM_REQ-1:0] rd_tag;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PW-1:0]      win;
  logic [PW-1:0]      ptr_nxt;
  logic [LW-1:0]      cnt_base;
  logic               own_hit;
  logic               any_gnt;
  logic               keep;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  // an owner that dropped req loses the port and normal arbitration runs now
  always_comb begin
    own_hit = owner_v & req[owner];
    gnt_c   = own_hit ? (NUM_REQ'(1) << owner) : pick;
    gnt     = reset ? gnt_c : '0;
    any_gnt = |gnt;
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win = PW'(i);
    end
  end

  always_comb begin
    mem_en    = any_gnt;
    mem_wr_en = any_gnt & we[win];
    mem_addr  = any_gnt ? addr[win*ADDR_W +: ADDR_W] : '0;
    mem_wdata = any_gnt ? wdata[win*DATA_W +: DATA_W] : '0;
  end

  // a new winner starts its lock budget from zero
  always_comb begin
    ptr_nxt  = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    cnt_base = own_hit ? lock_cnt : '0;
    keep     = lock[win] && (cnt_base < LW'(MAX_LOCK - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr      <= '0;
      owner    <= '0;
      owner_v  <= 1'b0;
      lock_cnt <= '0;
      rd_tag   <= '0;
    end else if (any_gnt) begin
      ptr      <= ptr_nxt;
      owner    <= keep ? win : '0;
      owner_v  <= keep;
      lock_cnt <= keep ? cnt_base + LW'(1) : '0;
      rd_tag   <= mem_wr_en ? '0 : gnt;
    end else begin
      owner    <= '0;
      owner_v  <= 1'b0;
      lock_cnt <= '0;
      rd_tag   <= '0;
    end
  end

  assign rvalid = reset ? rd_tag : '0;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cases plus random traffic vs a model.
// Drives inputs 1ns after posedge, checks outputs at negedge.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int ML = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en, mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .MAX_LOCK (ML)
  ) dut (
    .clk (clk), .reset (reset), .req (req), .we (we), .lock (lock),
    .addr (addr), .wdata (wdata), .gnt (gnt), .rvalid (rvalid),
    .rdata (rdata), .mem_en (mem_en), .mem_wr_en (mem_wr_en),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  // memory behind the arbiter
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en && mem_wr_en) mem[mem_addr] = mem_wdata;
    else if (mem_en) mem_rdata <= mem.exists(mem_addr) ?
      mem[mem_addr] : init_val(mem_addr);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [DW-1:0] mmem [logic [AW-1:0]];
  int m_ptr = 0, m_owner = -1, m_cnt = 0, m_rv = -1;
  logic [DW-1:0] m_rdat = '0;

  always @(negedge clk) begin
    int eg, cont;
    logic [AW-1:0] a;
    eg = -1;
    if (reset === 1'b1) begin
      if (m_owner >= 0 && req[m_owner]) eg = m_owner;
      else
        for (int k = 0; k < N; k++)
          if (eg < 0 && req[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
    end
    a = (eg >= 0) ? addr[eg*AW +: AW] : '0;
    chk("gnt", DW'(gnt), (eg >= 0) ? DW'(1) << eg : '0);
    chk("mem_en", DW'(mem_en), DW'(eg >= 0));
    chk("mem_wr_en", DW'(mem_wr_en), (eg >= 0) ? DW'(we[eg]) : '0);
    chk("mem_addr", DW'(mem_addr), DW'(a));
    chk("mem_wdata", mem_wdata, (eg >= 0) ? wdata[eg*DW +: DW] : '0);
    chk("rvalid", DW'(rvalid),
        (reset === 1'b1 && m_rv >= 0) ? DW'(1) << m_rv : '0);
    if (reset === 1'b1 && m_rv >= 0) chk("rdata", rdata, m_rdat);
    if (reset !== 1'b1) begin
      m_ptr = 0; m_owner = -1; m_cnt = 0; m_rv = -1;
    end else if (eg >= 0) begin
      cont = (eg == m_owner) ? m_cnt : 0;
      m_ptr = (eg + 1) % N;
      if (lock[eg] && cont + 1 < ML) begin
        m_owner = eg; m_cnt = cont + 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      if (we[eg]) begin
        mmem[a] = wdata[eg*DW +: DW];
        m_rv = -1;
      end else begin
        m_rv = eg;
        m_rdat = mmem.exists(a) ? mmem[a] : init_val(a);
      end
    end else begin
      m_owner = -1; m_cnt = 0; m_rv = -1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [N-1:0] exp_seq;
    mem[32'h10] = 64'hDEAD_BEEF;
    mmem[32'h10] = 64'hDEAD_BEEF;
    mem_rdata = '0;
    reset = 1'b0; req = 3'b111; we = '0; lock = '0;
    addr = '0; wdata = '0;

    // 1: reset held two cycles
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", DW'(gnt), 0);
      chk("rst_mem_en", DW'(mem_en), 0);
      chk("rst_rvalid", DW'(rvalid), 0);
    end
    step(); reset = 1'b1;

    // 2: plain round robin
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_seq = 3'b001 << (c % 3);
      chk("rr_seq", DW'(gnt), DW'(exp_seq));
      step();
    end

    // 3: read by NIC RX
    req = 3'b010; we = '0;
    set_a(int'(REQ_NIC_RX), 32'h10, '0);
    @(negedge clk);
    chk("rd_gnt", DW'(gnt), 64'h2);
    chk("rd_addr", DW'(mem_addr), 64'h10);
    chk("rd_wr_en", DW'(mem_wr_en), 0);
    step(); req = '0;
    @(negedge clk);
    chk("rd_rvalid", DW'(rvalid), 64'h2);
    chk("rd_rdata", rdata, 64'hDEAD_BEEF);
    step();

    // 4: CPU lock bound
    req = 3'b011; lock = 3'b001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("lock_seq", DW'(gnt), (c < 4) ? 64'h1 : 64'h2);
      step();
    end
    req = '0; lock = '0;
    step();

    // 5: reset right after a read grant
    req = 3'b100;
    @(negedge clk);
    chk("rst_rd_gnt", DW'(gnt), 64'h4);
    step(); reset = 1'b0; req = '0;
    @(negedge clk);
    chk("rst_rd_rvalid", DW'(rvalid), 0);
    step(); reset = 1'b1; req = 3'b111;
    @(negedge clk);
    chk("rst_rd_rvalid2", DW'(rvalid), 0);
    chk("rst_ptr_gnt", DW'(gnt), 64'h1);
    step();

    // 6: write then read, same address
    req = 3'b001; we = 3'b001;
    set_a(int'(REQ_CPU), 32'h8, 64'h5);
    @(negedge clk);
    chk("wr_wr_en", DW'(mem_wr_en), 1);
    step();
    req = 3'b010; we = '0;
    set_a(int'(REQ_NIC_RX), 32'h8, '0);
    @(negedge clk);
    chk("rd2_gnt", DW'(gnt), 64'h2);
    chk("rd2_wr_en", DW'(mem_wr_en), 0);
    step(); req = '0;
    @(negedge clk);
    chk("rd2_rvalid", DW'(rvalid), 64'h2);
    chk("rd2_rdata", rdata, 64'h5);
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      req  = N'($urandom);
      we   = N'($urandom);
      lock = N'($urandom_range(3, 0) == 0 ? 0 : $urandom);
      for (int i = 0; i < N; i++)
        set_a(i, AW'($urandom_range(7, 0) * 8),
              {$urandom, $urandom});
      if ($urandom_range(199, 0) == 0) reset = 1'b0;
      else reset = 1'b1;
      step();
    end
    reset = 1'b1; req = '0;
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
